// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART blocks on the clk_3125 domain (uart_rx,
// uart_tx and the transmit arbiter in front of uart_tx).
//
// Contents:
//   BIT_CYCLES       clocks per serial bit
//   FRAME_CYCLES     clocks per full frame (start + 8 data + parity + stop)
//   PARITY_ERR_CHAR  substitute byte uart_rx emits on a parity error
//   arb_state_t      transmit arbiter state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned BIT_CYCLES      = 14;
    localparam int unsigned FRAME_CYCLES    = BIT_CYCLES * 11;  // 154
    localparam logic [7:0]  PARITY_ERR_CHAR = 8'h3F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // nothing in flight, arbitration enabled
        WAIT = 2'd1,   // byte handed to uart_tx, waiting for tx_done
        GAP  = 2'd2    // post-frame idle gap, requests not sampled
    } arb_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Combinational rotate-priority encoder. Starting at index ptr and wrapping
// modulo NREQ, returns the first set bit of req.
//
// Parameters:
//   NREQ    number of request lines (2..8)
//
// Ports:
//   req     in   NREQ           request vector
//   ptr     in   $clog2(NREQ)   index with highest priority this cycle
//   gnt_id  out  $clog2(NREQ)   winning index (0 when any is low)
//   any     out  1              at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
    import uart_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    // One extra bit so ptr + offset can exceed NREQ-1 before wrapping.
    logic [ID_W:0] idx_sum;
    logic          found;

    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves it unassigned; otherwise a latch would be inferred.
        gnt_id  = '0;
        found   = 1'b0;
        idx_sum = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx_sum >= (ID_W+1)'(NREQ)) begin
                idx_sum = idx_sum - (ID_W+1)'(NREQ);
            end
            if (!found && req[idx_sum[ID_W-1:0]]) begin
                found  = 1'b1;
                gnt_id = idx_sum[ID_W-1:0];
            end
        end
    end

    assign any = |req;

endmodule : rr_pick

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter sharing one uart_tx serializer among NREQ byte
// requesters. In IDLE it grants the first pending requester at or after the
// round-robin pointer, latches its byte onto tx_data, pulses req_ready/tx_start
// and waits in WAIT for tx_done. An optional GAP of GAP_CYCLES clocks follows
// each frame before arbitration resumes.
//
// Optional feature (macro UART_ARB_TIMEOUT_EN):
//   A watchdog counts WAIT clocks; after TIMEOUT_CYCLES without tx_done the
//   frame is abandoned as if done and the sticky timeout_err flag is set.
//   Without the macro WAIT lasts until tx_done and timeout_err is tied 0.
//
// Parameters:
//   NREQ            requesters (2..8)
//   GAP_CYCLES      idle clocks after each tx_done
//   TIMEOUT_CYCLES  WAIT watchdog limit (macro builds only)
//
// Ports:
//   clk_3125     in   1        system clock, rising edge
//   rst          in   1        asynchronous active-high reset
//   req_valid    in   NREQ     requester i has a byte pending
//   req_data     in   8*NREQ   byte of requester i at [8*i +: 8]
//   req_ready    out  NREQ     one-cycle one-hot accept pulse
//   tx_start     out  1        one-cycle start pulse to uart_tx
//   tx_data      out  8        byte being serialized
//   tx_done      in   1        end-of-frame pulse from uart_tx
//   busy         out  1        state is not IDLE
//   grant_id     out  ID_W     last/current granted requester
//   timeout_err  out  1        sticky watchdog flag
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned NREQ           = 4,
    parameter  int unsigned GAP_CYCLES     = 0,
    parameter  int unsigned TIMEOUT_CYCLES = 200,
    localparam int unsigned ID_W           = $clog2(NREQ)
) (
    input  logic              clk_3125,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic [ID_W-1:0]   grant_id,
    output logic              timeout_err
);

    // Gap counter only needs to reach GAP_CYCLES-1; keep at least one bit so
    // the default GAP_CYCLES=0 build still elaborates.
    localparam int unsigned   GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned   WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
`endif

    // ---------------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------------
    arb_state_t        state_q,     state_d;
    logic [ID_W-1:0]   ptr_q,       ptr_d;
    logic [7:0]        tx_data_q,   tx_data_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic              tx_start_q,  tx_start_d;
    logic              busy_q,      busy_d;
    logic [ID_W-1:0]   grant_id_q,  grant_id_d;
    logic [GAP_W-1:0]  gap_cnt_q,   gap_cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
    logic [WD_W-1:0]   wd_cnt_q,    wd_cnt_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    logic [ID_W-1:0]   pick_id;
    logic              pick_any;
    logic [7:0]        sel_byte;
    logic              frame_end;

    rr_pick #(
        .NREQ   (NREQ)
    ) u_rr_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    // Byte of the requester the encoder picked this cycle.
    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_id == ID_W'(i)) begin
                sel_byte = req_data[8*i +: 8];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        tx_data_d   = tx_data_q;
        req_ready_d = '0;
        tx_start_d  = 1'b0;
        grant_id_d  = grant_id_q;
        gap_cnt_d   = gap_cnt_q;
        frame_end   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    tx_data_d            = sel_byte;
                    req_ready_d[pick_id] = 1'b1;
                    tx_start_d           = 1'b1;
                    grant_id_d           = pick_id;
                    // Pointer moves past the winner so it gets lowest
                    // priority next time; it never moves without a grant.
                    ptr_d = (pick_id == ID_W'(NREQ - 1)) ? '0 : pick_id + 1'b1;
                    state_d = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                    wd_cnt_d = '0;
`endif
                end
            end

            WAIT: begin
                // A tx_done coincident with our own tx_start belongs to the
                // previous frame (or is spurious) and is ignored.
                frame_end = tx_done && !tx_start_q;
`ifdef UART_ARB_TIMEOUT_EN
                if (!frame_end) begin
                    if (wd_cnt_q == WD_LAST) begin
                        frame_end     = 1'b1;
                        timeout_err_d = 1'b1;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end
`endif
                if (frame_end) begin
                    if (GAP_CYCLES > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        // Registered decode of the next state so busy rises with WAIT.
        busy_d = (state_d != IDLE);
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_3125 or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            tx_data_q   <= 8'h00;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            grant_id_q  <= '0;
            gap_cnt_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            tx_data_q   <= tx_data_d;
            req_ready_q <= req_ready_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            grant_id_q  <= grant_id_d;
            gap_cnt_q   <= gap_cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter (NREQ=4, GAP_CYCLES=0,
// TIMEOUT_CYCLES=200). Requesters are modelled as per-port byte queues, the
// serializer as a fixed-length frame followed by a tx_done pulse, and the
// expected grant as "first pending port at or after the pointer, wrapping".
// Honours UART_ARB_TIMEOUT_EN in the watchdog scenario.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 154;
    localparam int TMO   = 200;

    logic          clk_3125 = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_done;
    logic          busy;
    logic [1:0]    grant_id;
    logic          timeout_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int         ptr_m = 0;
    logic [7:0] q [N][$];

    int order     [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int g;
    bit quiet;

    uart_tx_arbiter #(
        .NREQ           (N),
        .GAP_CYCLES     (0),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_3125    (clk_3125),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #160 clk_3125 = ~clk_3125;

    task automatic tick();
        @(posedge clk_3125);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // First pending port at or after p, wrapping modulo N.
    function automatic int model_pick(input logic [N-1:0] v, input int p);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (v[j[1:0]]) return j;
        end
        return -1;
    endfunction

    // Each requester presents the head of its queue; empty ports show junk.
    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = q[i][0];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"},   32'(req_ready),   32'h0);
        check({tag, "_tx_start"},    32'(tx_start),    32'h0);
        check({tag, "_tx_data"},     32'(tx_data),     32'h0);
        check({tag, "_busy"},        32'(busy),        32'h0);
        check({tag, "_grant_id"},    32'(grant_id),    32'h0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'h0);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check_reset(tag);
        tick();
        tick();
        rst   = 1'b0;
        ptr_m = 0;
    endtask

    // Wait (bounded) for the next grant and compare against the model.
    // Leaves the bench in the tx_start cycle.
    task automatic expect_grant(input string tag, output int gid);
        logic [N-1:0] v;
        int exp_g;
        bit got;
        int lat;
        v     = req_valid;
        exp_g = model_pick(v, ptr_m);
        got   = 1'b0;
        lat   = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (tx_start === 1'b1) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        gid = exp_g;
        check({tag, "_start_seen"}, 32'(got), 32'h1);
        if (got && exp_g >= 0) begin
            check({tag, "_latency"},   32'(lat),       32'h0);
            check({tag, "_req_ready"}, 32'(req_ready), 32'(1 << exp_g));
            check({tag, "_grant_id"},  32'(grant_id),  32'(exp_g));
            check({tag, "_tx_data"},   32'(tx_data),   32'(q[exp_g][0]));
            check({tag, "_busy"},      32'(busy),      32'h1);
            void'(q[exp_g].pop_front());
            ptr_m = (exp_g + 1) % N;
            drive_reqs();
        end
    endtask

    // Serializer model: tx_done sampled len clocks after the tx_start edge.
    // With early set, a tx_done is also driven during the tx_start cycle.
    task automatic finish_frame(input string tag, input int len, input bit early);
        logic [7:0] d0;
        bit stable;
        d0     = tx_data;
        stable = 1'b1;
        if (early) tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check({tag, "_pulses_end"}, 32'({req_ready, tx_start}), 32'h0);
        if (early) check({tag, "_early_done_ignored"}, 32'(busy), 32'h1);
        for (int i = 0; i < len - 2; i++) begin
            if (tx_data !== d0 || busy !== 1'b1) stable = 1'b0;
            tick();
        end
        if (tx_data !== d0 || busy !== 1'b1) stable = 1'b0;
        check({tag, "_hold"}, 32'(stable), 32'h1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check({tag, "_idle_after_done"}, 32'(busy), 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_done   = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset("rst_init");
        rst = 1'b0;

        // No requests: stays idle
        quiet = 1'b1;
        repeat (4) begin
            tick();
            if (busy !== 1'b0 || tx_start !== 1'b0) quiet = 1'b0;
        end
        check("idle_stay", 32'(quiet), 32'h1);

        // Single request on port 1
        q[1].push_back(8'h41);
        drive_reqs();
        expect_grant("single", g);
        check("single_ready_0010", 32'(req_ready), 32'h2);
        check("single_data_41",    32'(tx_data),   32'h41);
        check("single_id_1",       32'(grant_id),  32'h1);
        finish_frame("single", FRAME, 1'b0);

        // Fairness: all four ports pending, order 0,1,2,3,0
        pulse_reset("rst_fair");
        for (int i = 0; i < N; i++) q[i].push_back(8'(8'h30 + i));
        q[0].push_back(8'h34);
        drive_reqs();
        for (int f = 0; f < 5; f++) begin
            expect_grant($sformatf("fair%0d", f), g);
            order[f] = int'(grant_id);
            finish_frame($sformatf("fair%0d", f), FRAME, 1'b0);
        end
        for (int f = 0; f < 5; f++) begin
            check($sformatf("fair_order%0d", f), 32'(order[f]), 32'(exp_order[f]));
        end

        // Rotation: grant port 2, then 0101 must go 0 then 2
        q[2].push_back(8'h52);
        drive_reqs();
        expect_grant("rot_a", g);
        check("rot_a_id_2", 32'(grant_id), 32'h2);
        q[0].push_back(8'h50);
        q[2].push_back(8'h53);
        drive_reqs();
        finish_frame("rot_a", FRAME, 1'b0);
        expect_grant("rot_b", g);
        check("rot_b_id_0", 32'(grant_id), 32'h0);
        finish_frame("rot_b", FRAME, 1'b0);
        expect_grant("rot_c", g);
        check("rot_c_id_2", 32'(grant_id), 32'h2);
        finish_frame("rot_c", FRAME, 1'b0);

        // Early tx_done in the tx_start cycle is ignored
        q[3].push_back(8'h63);
        drive_reqs();
        expect_grant("early", g);
        finish_frame("early", FRAME, 1'b1);

        // Reset 50 clocks into WAIT; pointer returns to 0
        q[1].push_back(8'h71);
        drive_reqs();
        expect_grant("mid", g);
        q[0].push_back(8'h70);
        q[3].push_back(8'h73);
        drive_reqs();
        repeat (50) tick();
        pulse_reset("rst_mid");
        expect_grant("after_rst", g);
        check("after_rst_lowest_0", 32'(grant_id), 32'h0);
        finish_frame("after_rst", FRAME, 1'b0);
        expect_grant("after_rst2", g);
        finish_frame("after_rst2", FRAME, 1'b0);

        // Watchdog: frame with no tx_done, port 3 pending behind it
        q[2].push_back(8'h82);
        drive_reqs();
        expect_grant("wd", g);
        q[3].push_back(8'h83);
        drive_reqs();
`ifdef UART_ARB_TIMEOUT_EN
        repeat (TMO - 1) tick();
        check("wd_not_yet",  32'(timeout_err), 32'h0);
        check("wd_busy_199", 32'(busy),        32'h1);
        tick();
        check("wd_set",      32'(timeout_err), 32'h1);
        check("wd_idle",     32'(busy),        32'h0);
        expect_grant("wd_next", g);
        check("wd_next_id_3", 32'(grant_id), 32'h3);
        finish_frame("wd_next", FRAME, 1'b0);
        check("wd_sticky", 32'(timeout_err), 32'h1);
        pulse_reset("rst_wd");
`else
        repeat (TMO + 50) tick();
        check("wd_busy_held", 32'(busy),        32'h1);
        check("wd_no_err",    32'(timeout_err), 32'h0);
        check("wd_no_grant",  32'({req_ready, tx_start}), 32'h0);
        pulse_reset("rst_wd");
        expect_grant("wd_after_rst", g);
        check("wd_after_rst_id_3", 32'(grant_id), 32'h3);
        finish_frame("wd_after_rst", FRAME, 1'b0);
`endif

        // Randomized traffic against the model
        for (int f = 0; f < 24; f++) begin
            bool_push: begin
                bit any_q;
                any_q = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (q[i].size() < 2 && $urandom_range(0, 2) == 0)
                        q[i].push_back(8'($urandom));
                    if (q[i].size() > 0) any_q = 1'b1;
                end
                if (!any_q) q[$urandom_range(0, N-1)].push_back(8'($urandom));
            end
            drive_reqs();
            expect_grant($sformatf("rnd%0d", f), g);
            finish_frame($sformatf("rnd%0d", f), int'($urandom_range(2, 40)),
                         ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
